// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel mode
// encodings and the per-channel configuration record.
package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Divisor width of the configuration record (matches the default N_BIT)
    localparam int unsigned CFG_DIV_W = 16;

    typedef struct packed {
        logic                 mode;
        logic [CFG_DIV_W-1:0] div;
    } chan_cfg_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: periodic divider or retriggerable one-shot with a
// registered single-cycle tick strobe and a busy flag.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int          N_BIT     = 16,
    parameter int unsigned DEFAULT_N = 50000
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             sync,
    input  logic             wr_hit,
    input  logic [N_BIT-1:0] wr_div,
    input  logic             wr_oneshot,
    output logic             tick,
    output logic             busy
);

    localparam logic [N_BIT-1:0] ZERO_C = {N_BIT{1'b0}};
    localparam logic [N_BIT-1:0] ONE_C  = {{(N_BIT-1){1'b0}}, 1'b1};
    localparam logic [N_BIT-1:0] RST_DIV_C = N_BIT'(DEFAULT_N);

    logic [N_BIT-1:0] count_r;
    logic [N_BIT-1:0] div_r;
    logic             mode_r;
    logic             busy_r;
    logic             tick_r;

    logic [N_BIT-1:0] count_s;
    logic [N_BIT-1:0] div_s;
    logic             mode_s;
    logic             busy_s;
    logic             tick_s;

    // Next-state: counting rules first, then a config write layered on top
    always_comb begin
        count_s = count_r;
        div_s   = div_r;
        mode_s  = mode_r;
        busy_s  = busy_r;
        tick_s  = 1'b0;

        if (enable == 1'b0) begin
            tick_s = 1'b0;
        end else if (mode_r == MODE_PERIODIC) begin
            if (sync == 1'b1) begin
                count_s = div_r;
            end else if (count_r == ZERO_C) begin
                tick_s  = 1'b1;
                count_s = div_r;
            end else begin
                count_s = count_r - ONE_C;
            end
        end else begin
            if (start == 1'b1) begin
                count_s = div_r;
                busy_s  = 1'b1;
            end else if ((busy_r == 1'b1) && (count_r == ZERO_C)) begin
                tick_s = 1'b1;
                busy_s = 1'b0;
            end else if (busy_r == 1'b1) begin
                count_s = count_r - ONE_C;
            end else begin
                tick_s = 1'b0;
            end
        end

        // Same-mode write only swaps the divisor (any reload above already
        // used the old one); a mode change aborts the channel.
        if (wr_hit == 1'b1) begin
            div_s = wr_div;
            if (wr_oneshot != mode_r) begin
                mode_s  = wr_oneshot;
                count_s = ZERO_C;
                busy_s  = 1'b0;
                tick_s  = 1'b0;
            end else begin
                mode_s = mode_r;
            end
        end else begin
            div_s = div_r;
        end
    end

    // Channel state registers with synchronous reset
    always_ff @(posedge clkin) begin
        if (rst) begin
            count_r <= ZERO_C;
            div_r   <= RST_DIV_C;
            mode_r  <= MODE_PERIODIC;
            busy_r  <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            div_r   <= div_s;
            mode_r  <= mode_s;
            busy_r  <= busy_s;
            tick_r  <= tick_s;
        end
    end

    assign tick = tick_r;
    assign busy = busy_r;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: decodes the shared write
// port into per-channel hits and replicates tick_chan N_CH times.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int          N_CH      = 4,
    parameter int          N_BIT     = 16,
    parameter int unsigned DEFAULT_N = 50000,
    parameter int          CH_W      = 2
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic [N_CH-1:0]   enable,
    input  logic [N_CH-1:0]   start,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [N_BIT-1:0]  wr_div,
    input  logic              wr_oneshot,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   busy
);

    logic [N_CH-1:0] wr_hit_s;

    // Write decode; addresses >= N_CH match no channel and are dropped
    always_comb begin
        wr_hit_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            wr_hit_s[i] = wr_en & (wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        tick_chan #(
            .N_BIT     (N_BIT),
            .DEFAULT_N (DEFAULT_N)
        ) u_chan (
            .clkin      (clkin),
            .rst        (rst),
            .enable     (enable[g]),
            .start      (start[g]),
            .sync       (sync),
            .wr_hit     (wr_hit_s[g]),
            .wr_div     (wr_div),
            .wr_oneshot (wr_oneshot),
            .tick       (tick[g]),
            .busy       (busy[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Table-driven bench for tick_gen_multi with hand-computed expectations,
// plus a short sequence on a 3-channel instance for out-of-range writes.
module tb_tick_gen_multi;
    import tick_gen_pkg::*;

    logic        clkin;
    logic        rst;
    logic [3:0]  enable;
    logic [3:0]  start;
    logic        sync;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic        wr_oneshot;
    logic [3:0]  tick;
    logic [3:0]  busy;
    logic [2:0]  enable3;
    logic [2:0]  start3;
    logic [2:0]  tick3;
    logic [2:0]  busy3;

    int total = 0;
    int bad   = 0;

    tick_gen_multi #(.N_CH(4), .N_BIT(16), .DEFAULT_N(4), .CH_W(2)) u_dut (
        .clkin(clkin), .rst(rst), .enable(enable), .start(start), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_oneshot(wr_oneshot),
        .tick(tick), .busy(busy)
    );

    tick_gen_multi #(.N_CH(3), .N_BIT(16), .DEFAULT_N(4), .CH_W(2)) u_dut3 (
        .clkin(clkin), .rst(rst), .enable(enable3), .start(start3), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_oneshot(wr_oneshot),
        .tick(tick3), .busy(busy3)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    typedef struct {
        logic        r;
        logic [3:0]  en;
        logic [3:0]  st;
        logic        sy;
        logic        we;
        logic [1:0]  wc;
        logic [15:0] wd;
        logic        wo;
        logic [3:0]  et;
        logic [3:0]  eb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] en, input logic [3:0] st,
                       input logic sy, input logic we, input logic [1:0] wc,
                       input logic [15:0] wd, input logic wo,
                       input logic [3:0] et, input logic [3:0] eb);
        vec_t v;
        v.r = r; v.en = en; v.st = st; v.sy = sy; v.we = we;
        v.wc = wc; v.wd = wd; v.wo = wo; v.et = et; v.eb = eb;
        vecs.push_back(v);
    endtask

    task automatic rs(input logic [3:0] en);
        add(1'b1, en, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic run(input logic [3:0] en, input logic [3:0] st, input logic sy,
                       input logic [3:0] et, input logic [3:0] eb);
        add(1'b0, en, st, sy, 1'b0, 2'd0, 16'd0, 1'b0, et, eb);
    endtask

    task automatic wr(input logic [1:0] ch, input chan_cfg_t cfg, input logic [3:0] en,
                      input logic [3:0] et, input logic [3:0] eb);
        add(1'b0, en, 4'b0000, 1'b0, 1'b1, ch, cfg.div, cfg.mode, et, eb);
    endtask

    function automatic chan_cfg_t mk(input logic mode, input logic [15:0] div);
        chan_cfg_t c;
        c.mode = mode;
        c.div  = div;
        return c;
    endfunction

    task automatic check(input string nm, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 4'b0; start = 4'b0; sync = 1'b0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0; wr_oneshot = 1'b0;
        enable3 = 3'b000; start3 = 3'b000;

        // 1: reset state, then ch0 default div 4 -> period 5 from first edge
        rs(4'b0000); rs(4'b0000);
        for (int e = 0; e < 11; e++)
            run(4'b0001, 4'b0000, 1'b0, ((e % 5) == 0) ? 4'b0001 : 4'b0000, 4'b0000);

        // 2: ch1 div 2, enable dropped 3 cycles mid-count stretches one period by 3
        rs(4'b0000);
        wr(2'd1, mk(MODE_PERIODIC, 16'd2), 4'b0000, 4'b0000, 4'b0000);
        for (int e = 1; e <= 13; e++)
            run((e >= 6 && e <= 8) ? 4'b0000 : 4'b0010, 4'b0000, 1'b0,
                (e == 1 || e == 4 || e == 10 || e == 13) ? 4'b0010 : 4'b0000, 4'b0000);

        // 3: ch2 one-shot div 3: latency, retrigger, start at count==0, abort
        rs(4'b0000);
        wr(2'd2, mk(MODE_ONESHOT, 16'd3), 4'b0100, 4'b0000, 4'b0000);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        for (int e = 0; e < 3; e++) run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
        run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        for (int e = 0; e < 3; e++) run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
        run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        for (int e = 0; e < 3; e++) run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        for (int e = 0; e < 3; e++) run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
        run(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
        run(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        wr(2'd2, mk(MODE_PERIODIC, 16'd3), 4'b0100, 4'b0000, 4'b0000);
        run(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
        run(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000);

        // 4: ch0/ch1 div 4 out of phase, sync aligns them 5 cycles later
        rs(4'b0000);
        wr(2'd1, mk(MODE_PERIODIC, 16'd4), 4'b0000, 4'b0000, 4'b0000);
        for (int e = 1; e <= 18; e++)
            run((e == 1) ? 4'b0001 : 4'b0011, 4'b0000, (e == 8),
                (e == 1 || e == 6) ? 4'b0001 :
                (e == 2 || e == 7) ? 4'b0010 :
                (e == 13 || e == 18) ? 4'b0011 : 4'b0000, 4'b0000);

        // 5: ch0 div 9, same-mode rewrite to 1 mid-count, rewrite on reload edge
        rs(4'b0000);
        wr(2'd0, mk(MODE_PERIODIC, 16'd9), 4'b0000, 4'b0000, 4'b0000);
        for (int e = 1; e <= 19; e++) begin
            if (e == 4)
                wr(2'd0, mk(MODE_PERIODIC, 16'd1), 4'b0001, 4'b0000, 4'b0000);
            else if (e == 13)
                wr(2'd0, mk(MODE_PERIODIC, 16'd3), 4'b0001, 4'b0001, 4'b0000);
            else
                run(4'b0001, 4'b0000, 1'b0,
                    (e == 1 || e == 11 || e == 15 || e == 19) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        // 6: reset while ch2 busy and ch0 mid-count; restart on first free edge
        rs(4'b0000);
        wr(2'd2, mk(MODE_ONESHOT, 16'd3), 4'b0000, 4'b0000, 4'b0000);
        run(4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0000);
        run(4'b0101, 4'b0100, 1'b0, 4'b0000, 4'b0100);
        rs(4'b0101);
        run(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0000);
        run(4'b0101, 4'b0000, 1'b0, 4'b0000, 4'b0000);

        // 7: div 0 periodic holds tick high while enabled
        rs(4'b0000);
        wr(2'd3, mk(MODE_PERIODIC, 16'd0), 4'b0000, 4'b0000, 4'b0000);
        for (int e = 0; e < 3; e++) run(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b0000);
        run(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; enable = vecs[i].en; start = vecs[i].st;
            sync = vecs[i].sy; wr_en = vecs[i].we; wr_ch = vecs[i].wc;
            wr_div = vecs[i].wd; wr_oneshot = vecs[i].wo;
            step();
            check("tick", i, tick, vecs[i].et);
            check("busy", i, busy, vecs[i].eb);
        end

        // Out-of-range write on the 3-channel instance must not disturb anything
        rst = 1'b1; enable = 4'b0000; start = 4'b0000; sync = 1'b0; wr_en = 1'b0;
        step();
        check("n3_rst_tick", 0, {1'b0, tick3}, 4'b0000);
        check("n3_rst_busy", 0, {1'b0, busy3}, 4'b0000);
        rst = 1'b0; enable3 = 3'b111;
        step();
        check("n3_tick", 1, {1'b0, tick3}, 4'b0111);
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd1; wr_oneshot = 1'b1;
        step();
        check("n3_tick", 2, {1'b0, tick3}, 4'b0000);
        wr_en = 1'b0;
        for (int e = 3; e <= 7; e++) begin
            step();
            check("n3_tick", e, {1'b0, tick3}, (e == 6) ? 4'b0111 : 4'b0000);
            check("n3_busy", e, {1'b0, busy3}, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
